// File: rtl/serial_adder_fsm.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first,
// operands in via start/ready, result out via out_valid/out_ready.
module serial_adder_fsm #(
  parameter int WIDTH  = 8,
  parameter int SUB_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             op;
  logic             fa_s, fa_c;

  assign op   = (SUB_EN != 0) & sub;

  // Operands shift right each RUN cycle so the slice always sees bit 0.
  assign fa_s = opa[0] ^ opb[0] ^ c;
  assign fa_c = (opa[0] & opb[0]) | (c & (opa[0] ^ opb[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= op ? ~b : b;
            c     <= op ? 1'b1 : cin;
            cnt   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[cnt] <= fa_s;
          c        <= fa_c;
          opa      <= opa >> 1;
          opb      <= opb >> 1;
          if (cnt == LAST) begin
            // c is the carry into the MSB here, fa_c the carry out of it.
            cout      <= fa_c;
            ovf       <= c ^ fa_c;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ready     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench: 8-bit add/sub instance plus WIDTH=1 and SUB_EN=0 corner instances.
module tb_serial_adder_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance, WIDTH=8 SUB_EN=1
  logic       start = 0, out_ready = 0, cin = 0, sub = 0;
  logic [7:0] a = 0, b = 0;
  logic       ready, cout, ovf, out_valid;
  logic [7:0] sum;

  // WIDTH=1 instance
  logic       start1 = 0, out_ready1 = 0, cin1 = 0, sub1 = 0;
  logic [0:0] a1 = 0, b1 = 0;
  logic       ready1, cout1, ovf1, out_valid1;
  logic [0:0] sum1;

  // SUB_EN=0 instance
  logic       startn = 0, out_readyn = 0, cinn = 0, subn = 0;
  logic [7:0] an = 0, bn = 0;
  logic       readyn, coutn, ovfn, out_validn;
  logic [7:0] sumn;

  serial_adder_fsm #(.WIDTH(8), .SUB_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .sum(sum), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready));

  serial_adder_fsm #(.WIDTH(1), .SUB_EN(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .out_valid(out_valid1), .out_ready(out_ready1));

  serial_adder_fsm #(.WIDTH(8), .SUB_EN(0)) u_ns (
    .clk(clk), .rst_n(rst_n), .start(startn), .ready(readyn), .a(an), .b(bn),
    .cin(cinn), .sub(subn), .sum(sumn), .cout(coutn), .ovf(ovfn),
    .out_valid(out_validn), .out_ready(out_readyn));

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } res_t;

  res_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input logic op, input int w);
    logic [63:0] m;
    logic [64:0] t;
    res_t        r;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x   = x & m;
    y   = (op ? ~y : y) & m;
    t   = {1'b0, x} + {1'b0, y} + {64'd0, (op ? 1'b1 : ci)};
    r.s  = t[63:0] & m;
    r.co = t[w];
    r.ov = (x[w-1] == y[w-1]) && (r.s[w-1] != x[w-1]);
    return r;
  endfunction

  task automatic pop_chk(input string tag, input logic [63:0] s, input logic co, input logic ov,
                         output res_t e);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      e = '{default: '0};
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, s, e.s);
      chk({tag, "_cout"}, co, e.co);
      chk({tag, "_ovf"}, ov, e.ov);
    end
  endtask

  // One operation on the main instance; hold_cyc cycles of backpressure with
  // start pulsed on fresh operands that must be ignored.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tci, input logic tsb, input int hold_cyc);
    int   lat;
    res_t e;
    @(negedge clk);
    chk({tag, "_ready_idle"}, ready, 1'b1);
    a = ta; b = tb; cin = tci; sub = tsb; start = 1'b1;
    sb.push_back(model(64'(ta), 64'(tb), tci, tsb, 8));
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk({tag, "_ready_run"}, ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    pop_chk(tag, 64'(sum), cout, ovf, e);
    for (int i = 0; i < hold_cyc; i++) begin
      start = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk({tag, "_bp_valid"}, out_valid, 1'b1);
      chk({tag, "_bp_ready"}, ready, 1'b0);
      chk({tag, "_bp_sum"}, 64'(sum), e.s);
      chk({tag, "_bp_cout"}, cout, e.co);
      chk({tag, "_bp_ovf"}, ovf, e.ov);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ready_after"}, ready, 1'b1);
    chk({tag, "_valid_after"}, out_valid, 1'b0);
    chk({tag, "_sum_kept"}, 64'(sum), e.s);
  endtask

  initial begin
    int   lat;
    res_t e;
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
    run_op("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op("add_cin", 8'h00, 8'h00, 1'b1, 1'b0, 0);
    run_op("sub1020", 8'h10, 8'h20, 1'b0, 1'b1, 0);
    run_op("sub8001", 8'h80, 8'h01, 1'b1, 1'b1, 0);
    run_op("bp", 8'h7F, 8'h01, 1'b0, 1'b0, 5);

    // asynchronous reset while bit 4 is in flight
    @(negedge clk);
    a = 8'hFF; b = 8'h00; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_sum", 64'(sum), 64'd0);
    chk("arst_ready", ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 0);

    for (int i = 0; i < 6; i++)
      run_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), i % 2);

    // WIDTH=1: single RUN cycle
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
    sb.push_back(model(64'd1, 64'd1, 1'b1, 1'b0, 1));
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    chk("w1_latency", 64'(lat), 64'd1);
    pop_chk("w1", 64'(sum1), cout1, ovf1, e);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("w1_ready_after", ready1, 1'b1);

    // SUB_EN=0: sub ignored, add semantics
    @(negedge clk);
    an = 8'h05; bn = 8'h03; cinn = 1'b0; subn = 1'b1; startn = 1'b1;
    sb.push_back(model(64'h05, 64'h03, 1'b0, 1'b0, 8));
    @(negedge clk);
    startn = 1'b0;
    lat = 0;
    while (!out_validn && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("ns_latency", 64'(lat), 64'd8);
    pop_chk("ns", 64'(sumn), coutn, ovfn, e);
    out_readyn = 1'b1;
    @(negedge clk);
    out_readyn = 1'b0;
    chk("ns_ready_after", readyn, 1'b1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder_fsm.md
Name: serial_adder_fsm

Overview:
Parametrised bit-serial adder/subtractor, the sequential successor to the combinational full-adder cell. A single full-adder slice and one carry flip-flop process WIDTH-bit operands LSB-first, one bit per clock. Operands enter through a start/ready handshake and the result leaves through a valid/ready handshake. Intended as a small sequential benchmark circuit for fault-injection and test-generation flows.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..64.
SUB_EN, 1, 1 enables subtract mode through the sub input; 0 ties sub to 0 internally.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  operand-valid request.
ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add mode only).
sub  input  1  1 = compute A-B, 0 = compute A+B+cin.
sum  output  WIDTH  result.
cout  output  1  carry-out (add); no-borrow flag (sub, 1 = A>=B unsigned).
ovf  output  1  two's-complement signed overflow.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock, rst_n clears all state immediately, regardless of clk.
- Reset values: state=IDLE, ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry FF=0, bit counter=0.
- States: IDLE, RUN, HOLD.
- IDLE: ready=1. When start=1 at a rising edge, capture a, b, op=(sub & SUB_EN) and move to RUN.
  - Captured B operand = op ? ~b : b.
  - Carry FF loads op ? 1 : cin.
- RUN: ready=0. Each cycle, bit i (counter, LSB first):
  - sum[i] <= A[i]^B'[i]^c.
  - c <= majority(A[i], B'[i], c).
  - Counter increments.
  - At i=WIDTH-1, also register cout = carry out of the MSB and ovf = carry-into-MSB XOR carry-out-of-MSB, then go to HOLD.
- Counter width is max(1, clog2(WIDTH)). There is no wrap beyond WIDTH-1.
- Latency: operands accepted at edge 0; out_valid rises after edge WIDTH. WIDTH=1 gives a single RUN cycle.
- HOLD: out_valid=1.
  - sum, cout and ovf stay stable until out_ready=1 at an edge, then the block returns to IDLE with out_valid=0.
  - sum, cout and ovf keep their last values in IDLE until the next RUN overwrites sum bit by bit.
- start while in RUN or HOLD is ignored, with no queuing. Operand inputs may change freely after acceptance.
- out_ready outside HOLD is ignored.
- Reset asserted mid-RUN or mid-HOLD aborts the operation; the block comes out of reset in IDLE with reset values. A partial result is never presented.
- With SUB_EN=0, sub has no effect and cout/ovf follow add semantics.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN cycles, handshake out).

Test Plan:
- WIDTH=8, add, a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, ovf=1; out_valid rises exactly 8 cycles after the start edge.
- Add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Sub, a=0x10, b=0x20 -> sum=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD and pulse start with new operands -> sum/cout/ovf/out_valid stable, ready=0, new operands not captured. Raise out_ready -> IDLE next cycle, ready=1.
- Drop rst_n for one cycle at RUN bit 4 -> out_valid=0, sum=0, ready=1 immediately (asynchronous). A following add 0x01+0x01 completes with sum=0x02.
- Corner widths: WIDTH=1, a=1, b=1, cin=1 -> sum=1, cout=1, result after 1 RUN cycle. SUB_EN=0, sub=1, a=0x05, b=0x03 -> sum=0x08 (add).
